// File: rtl/sync_fifo_fwft.sv
// Synchronous sample FIFO with selectable standard or first-word-fall-through read,
// fill level, almost-full/empty thresholds and sticky overflow/underflow flags.
module sync_fifo_fwft #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_LEVEL  = 12,
    parameter int AEMPTY_LEVEL = 4,
    parameter int FWFT         = 0
) (
    input  logic                         clk,
    input  logic                         rst_a,
    input  logic                         wr_en,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         rd_en,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [ADDR_WIDTH:0]          level,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         clr_flags
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_LVL  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_LVL  = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AEMPTY_LVL = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);
    localparam logic [ADDR_WIDTH:0]   LVL_ZERO   = '0;
    localparam logic [ADDR_WIDTH:0]   LVL_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]        wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]        rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]          level_q, level_d;
    logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                         valid_q, valid_d;
    logic                         ovf_q, ovf_d;
    logic                         udf_q, udf_d;

    logic                         wr_acc, rd_acc, load;
    logic [ADDR_WIDTH:0]          arr_cnt;

    assign full         = (level_q == DEPTH_LVL);
    assign empty        = (level_q == LVL_ZERO);
    assign almost_full  = (level_q >= AFULL_LVL);
    assign almost_empty = (level_q <= AEMPTY_LVL);
    assign level        = level_q;
    assign data_out     = dout_q;
    assign valid        = valid_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    always_comb begin
        wr_acc   = wr_en && !full;
        rd_acc   = 1'b0;
        load     = 1'b0;
        arr_cnt  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        dout_d   = dout_q;
        valid_d  = valid_q;

        if (FWFT != 0) begin
            // In FWFT mode the output register holds one of the counted words.
            rd_acc  = rd_en && valid_q;
            arr_cnt = level_q - {{ADDR_WIDTH{1'b0}}, valid_q};
            load    = (!valid_q || rd_acc) && (arr_cnt != LVL_ZERO);
            if (load) begin
                valid_d = 1'b1;
            end else if (rd_acc) begin
                valid_d = 1'b0;
            end
        end else begin
            rd_acc  = rd_en && !empty;
            load    = rd_acc;
            valid_d = rd_acc;
        end

        if (load) begin
            dout_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (wr_acc && !rd_acc) begin
            level_d = level_q + LVL_ONE;
        end else if (rd_acc && !wr_acc) begin
            level_d = level_q - LVL_ONE;
        end

        // A new error event in the same cycle as the clear keeps the flag set.
        ovf_d = (ovf_q && !clr_flags) || (wr_en && full);
        udf_d = (udf_q && !clr_flags) || (rd_en && !rd_acc);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

endmodule
